seq_divider: RTL

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, then a single
// sign-correction cycle. Supports unsigned and two's-complement operands.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    // Two's-complement negate when requested; the most-negative value maps to
    // itself, which is also its correct unsigned magnitude.
    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                     input logic            neg);
        logic signed [WIDTH-1:0] sv;
        sv = v;
        if (neg)
            return WIDTH'(-sv);
        return v;
    endfunction

    // One restoring step on {partial remainder, quotient}. The remainder stays
    // below the divisor, so the shifted value fits in WIDTH+1 bits.
    function automatic logic [2*WIDTH-1:0] restore_step(input logic [2*WIDTH-1:0] acc,
                                                        input logic [WIDTH-1:0]   dvsr);
        logic [2*WIDTH:0] sh;
        logic [WIDTH:0]   diff;
        sh   = {acc, 1'b0};
        diff = sh[2*WIDTH:WIDTH] - {1'b0, dvsr};
        if (diff[WIDTH])
            return sh[2*WIDTH-1:0];
        return {diff[WIDTH-1:0], sh[WIDTH-1:1], 1'b1};
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        dvsr_d    = dvsr_q;
        dvd_d     = dvd_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dbz_d     = dbz_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ITER;
                    cnt_d     = '0;
                    acc_d     = {{WIDTH{1'b0}},
                                 cond_negate(dividend, signed_mode & dividend[WIDTH-1])};
                    dvsr_d    = cond_negate(divisor, signed_mode & divisor[WIDTH-1]);
                    dvd_d     = dividend;
                    neg_quo_d = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = signed_mode & dividend[WIDTH-1];
                end
            end
            ITER: begin
                acc_d = restore_step(acc_q, dvsr_q);
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1))
                    state_d = FIX;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                // A zero divisor always has a zero magnitude, whatever the mode.
                if (dvsr_q == '0) begin
                    quo_d = '1;
                    rem_d = dvd_q;
                    dbz_d = 1'b1;
                end else begin
                    quo_d = cond_negate(acc_q[WIDTH-1:0], neg_quo_q);
                    rem_d = cond_negate(acc_q[2*WIDTH-1:WIDTH], neg_rem_q);
                    dbz_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            dvsr_q    <= '0;
            dvd_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            quo_q     <= '0;
            rem_q     <= '0;
            dbz_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            dvsr_q    <= dvsr_d;
            dvd_q     <= dvd_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dbz_q     <= dbz_d;
            done_q    <= done_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule
